reg_read_port: RTL and testbench

Read-side engine for the 16 x 32-bit register file. It sits opposite the write path (address decoder plus load-enabled registers) and replaces a bare 16:1 mux with a request/response read port. A requester issues a start address and a burst length. The block returns one register word per beat over a valid/ready handshake, wrapping the address modulo 16, and can forward a same-cycle write.

---
 rtl/reg_file_pkg.sv | 21 ++
 rtl/reg_mux_16.sv | 14 +
 rtl/reg_read_port.sv | 90 +++++++++
 tb/tb_reg_read_port.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants, FSM state type and register-extract helper for the 16 x 32-bit register file.
package reg_file_pkg;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Register i lives at bits [DATA_W*i +: DATA_W] of the flat array.
  function automatic logic [DATA_W-1:0] reg_word(
    input logic [NUM_REGS*DATA_W-1:0] flat,
    input logic [ADDR_W-1:0]          idx
  );
    return flat[int'(idx)*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/reg_mux_16.sv
// Combinational 16:1 DATA_W-wide register select.
module reg_mux_16
  import reg_file_pkg::*;
(
  input  logic [NUM_REGS*DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]          idx,
  output logic [DATA_W-1:0]          word
);

  always_comb begin
    word = reg_word(regs, idx);
  end

endmodule

// File: rtl/reg_read_port.sv
// Burst read port for the 16 x 32-bit register file with valid/ready response handshake.
// Optional same-edge write forwarding is enabled by defining READ_BYPASS_EN.
module reg_read_port
  import reg_file_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REGS*DATA_W-1:0] regs,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [ADDR_W:0]            req_len,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [ADDR_W-1:0]          rsp_addr,
  output logic                       rsp_last,
  input  logic                       wr_ld,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       busy
);

  state_t              state;
  logic [ADDR_W-1:0]   remaining;
  logic [ADDR_W-1:0]   ld_idx;
  logic [ADDR_W-1:0]   first_rem;
  logic [DATA_W-1:0]   mux_word;
  logic [DATA_W-1:0]   ld_word;

  // One mux serves both the first beat (request address) and every following beat.
  assign ld_idx    = (state == IDLE) ? req_addr : ADDR_W'(rsp_addr + 1'b1);
  assign first_rem = (req_len == '0) ? ADDR_W'(NUM_REGS - 1) : ADDR_W'(req_len - 1'b1);

  reg_mux_16 u_mux (
    .regs (regs),
    .idx  (ld_idx),
    .word (mux_word)
  );

`ifdef READ_BYPASS_EN
  // Forward a write landing on the same edge so the beat carries the post-edge value.
  assign ld_word = (wr_ld && (wr_addr == ld_idx)) ? wr_data : mux_word;
`else
  logic unused_wr;
  assign ld_word   = mux_word;
  assign unused_wr = ^{wr_ld, wr_addr, wr_data};
`endif

  assign req_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == SEND);
  assign busy      = (state == SEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rsp_data  <= '0;
      rsp_addr  <= '0;
      rsp_last  <= 1'b0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= SEND;
            rsp_data  <= ld_word;
            rsp_addr  <= req_addr;
            remaining <= first_rem;
            rsp_last  <= (first_rem == '0);
          end
        end
        SEND: begin
          if (rsp_ready) begin
            if (rsp_last) begin
              state    <= IDLE;
              rsp_last <= 1'b0;
            end else begin
              rsp_data  <= ld_word;
              rsp_addr  <= ld_idx;
              remaining <= remaining - 1'b1;
              rsp_last  <= (remaining == ADDR_W'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_read_port.sv
// Scoreboard bench for reg_read_port: directed bursts, wrap, backpressure, write conflict, reset mid-burst.
module tb_reg_read_port;
  import reg_file_pkg::*;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
    logic              l;
  } beat_t;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [NUM_REGS*DATA_W-1:0] regs;
  logic                       req_valid = 1'b0;
  logic                       req_ready;
  logic [ADDR_W-1:0]          req_addr = '0;
  logic [ADDR_W:0]            req_len = '0;
  logic                       rsp_valid;
  logic                       rsp_ready = 1'b1;
  logic [DATA_W-1:0]          rsp_data;
  logic [ADDR_W-1:0]          rsp_addr;
  logic                       rsp_last;
  logic                       wr_ld = 1'b0;
  logic [ADDR_W-1:0]          wr_addr = '0;
  logic [DATA_W-1:0]          wr_data = '0;
  logic                       busy;

  logic [DATA_W-1:0] mem [NUM_REGS];
  beat_t             sb [$];
  beat_t             mon_e;
  int                n_vec = 0;
  int                n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    regs = '0;
    for (int i = 0; i < NUM_REGS; i++) regs[i*DATA_W +: DATA_W] = mem[i];
  end

  reg_read_port dut (
    .clk       (clk),
    .rst       (rst),
    .regs      (regs),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .rsp_last  (rsp_last),
    .wr_ld     (wr_ld),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected beat: got addr %h data %h, expected none", rsp_addr, rsp_data);
      end else begin
        mon_e = sb.pop_front();
        check("beat data", rsp_data, mon_e.d);
        check("beat addr", 32'(rsp_addr), 32'(mon_e.a));
        check("beat last", 32'(rsp_last), 32'(mon_e.l));
      end
    end
  end

  task automatic push_burst(input logic [3:0] a, input logic [4:0] l);
    int n;
    logic [3:0] ad;
    n = (l == 0) ? 16 : int'(l);
    for (int i = 0; i < n; i++) begin
      ad = 4'(int'(a) + i);
      sb.push_back({mem[ad], ad, (i == n - 1)});
    end
  endtask

  task automatic do_req(input logic [3:0] a, input logic [4:0] l);
    int k;
    k = 0;
    while (!req_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (!req_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL req_ready timeout: got 0, expected 1");
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = ~a;
    req_len   = 5'd7;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("idle reached", 32'(busy), 32'(0));
  endtask

  task automatic run_burst(input logic [3:0] a, input logic [4:0] l, input int n);
    int cnt;
    push_burst(a, l);
    do_req(a, l);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) cnt++;
      else break;
    end
    check("busy cycles", 32'(cnt), 32'(n));
    check("req_ready after burst", 32'(req_ready), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] h_data;
    logic [ADDR_W-1:0] h_addr;
    logic              h_last;
    int                seen;

    for (int i = 0; i < NUM_REGS; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[5] = 32'hAABB_AABB;
    mem[3] = 32'h0000_0000;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset rsp_valid", 32'(rsp_valid), 32'(0));
    check("reset rsp_data", rsp_data, 32'h0);
    check("reset rsp_addr", 32'(rsp_addr), 32'(0));
    check("reset rsp_last", 32'(rsp_last), 32'(0));
    check("reset busy", 32'(busy), 32'(0));
    check("reset req_ready", 32'(req_ready), 32'(0));
    rst = 1'b0;
    #1;
    check("req_ready after reset", 32'(req_ready), 32'(1));

    // Single read, wrap burst, length zero
    run_burst(4'd5, 5'd1, 1);
    run_burst(4'd14, 5'd4, 4);
    run_burst(4'd0, 5'd0, 16);
    run_burst(4'd9, 5'd16, 16);

    // Backpressure on the addr-15 beat of a wrap burst
    @(posedge clk); #1;
    push_burst(4'd14, 5'd4);
    do_req(4'd14, 5'd4);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    h_data = rsp_data;
    h_addr = rsp_addr;
    h_last = rsp_last;
    check("bp addr", 32'(h_addr), 32'(15));
    check("bp data", h_data, mem[15]);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp hold valid", 32'(rsp_valid), 32'(1));
      check("bp hold data", rsp_data, h_data);
      check("bp hold addr", 32'(rsp_addr), 32'(h_addr));
      check("bp hold last", 32'(rsp_last), 32'(h_last));
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_idle();

    // Write landing on the edge that loads beat addr 3
    @(posedge clk); #1;
    sb.push_back({mem[2], 4'd2, 1'b0});
`ifdef READ_BYPASS_EN
    sb.push_back({32'h1234_5678, 4'd3, 1'b0});
`else
    sb.push_back({32'h0000_0000, 4'd3, 1'b0});
`endif
    sb.push_back({mem[4], 4'd4, 1'b1});
    do_req(4'd2, 5'd3);
    wr_ld   = 1'b1;
    wr_addr = 4'd3;
    wr_data = 32'h1234_5678;
    @(posedge clk); #1;
    wr_ld   = 1'b0;
    wr_addr = 4'd0;
    wr_data = '0;
    mem[3]  = 32'h1234_5678;
    wait_idle();
    run_burst(4'd3, 5'd1, 1);

    // Reset during beat 2 of a len=8 burst
    @(posedge clk); #1;
    sb.push_back({mem[8], 4'd8, 1'b0});
    do_req(4'd8, 5'd8);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst rsp_valid", 32'(rsp_valid), 32'(0));
    check("midrst rsp_data", rsp_data, 32'h0);
    check("midrst rsp_addr", 32'(rsp_addr), 32'(0));
    check("midrst busy", 32'(busy), 32'(0));
    check("midrst req_ready", 32'(req_ready), 32'(1));
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("beats after reset", 32'(seen), 32'(0));
    check("scoreboard drained", 32'(sb.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
